// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - dot-product job sequencer driving one MAC accumulator slice
module mac_dot_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             MAC_ACC_CLK,
    input  logic             acc_ff_rstn,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [5:0]       cfg_out_sel,
    input  logic             cfg_rnd,
    input  logic             cfg_sat,
    input  logic             cfg_tc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_oper,
    input  logic [15:0]      in_coef,
    output logic             EFPGA_MATHB_CLK_EN,
    output logic [15:0]      MAC_OPER_DATA,
    output logic [15:0]      MAC_COEF_DATA,
    output logic             MAC_ACC_CLEAR,
    output logic             MAC_ACC_RND,
    output logic             MAC_ACC_SAT,
    output logic             MAC_TC,
    output logic [5:0]       MAC_OUT_SEL,
    input  logic [15:0]      MAC_OUT,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, CAPT, HOLD} state_t;

    state_t           state;
    logic [LEN_W-1:0] count;
    logic             first_beat;
    logic             rnd_mode;
    logic             beat;

    // in_ready is only ever high in RUN, so it alone qualifies a beat
    assign beat = in_valid & in_ready;

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            state              <= IDLE;
            count              <= '0;
            first_beat         <= 1'b0;
            rnd_mode           <= 1'b0;
            in_ready           <= 1'b0;
            EFPGA_MATHB_CLK_EN <= 1'b0;
            MAC_OPER_DATA      <= '0;
            MAC_COEF_DATA      <= '0;
            MAC_ACC_CLEAR      <= 1'b0;
            MAC_ACC_RND        <= 1'b0;
            MAC_ACC_SAT        <= 1'b0;
            MAC_TC             <= 1'b0;
            MAC_OUT_SEL        <= '0;
            res_valid          <= 1'b0;
            res_data           <= '0;
            busy               <= 1'b0;
        end else begin
            EFPGA_MATHB_CLK_EN <= 1'b0;
            MAC_ACC_CLEAR      <= 1'b0;
            MAC_ACC_RND        <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start && (cfg_len != '0)) begin
                        count       <= cfg_len;
                        MAC_OUT_SEL <= cfg_out_sel;
                        MAC_ACC_SAT <= cfg_sat;
                        MAC_TC      <= cfg_tc;
                        rnd_mode    <= cfg_rnd;
                        first_beat  <= 1'b1;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        MAC_OPER_DATA      <= in_oper;
                        MAC_COEF_DATA      <= in_coef;
                        EFPGA_MATHB_CLK_EN <= 1'b1;
                        // first product replaces the accumulator so no prior job leaks in
                        MAC_ACC_CLEAR      <= first_beat & ~rnd_mode;
                        MAC_ACC_RND        <= first_beat & rnd_mode;
                        first_beat         <= 1'b0;
                        count              <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: state <= CAPT;
                CAPT: begin
                    res_data  <= MAC_OUT;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        MAC_OUT_SEL <= '0;
                        MAC_ACC_SAT <= 1'b0;
                        MAC_TC      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb/tb_mac_dot_sequencer.sv - directed bench for mac_dot_sequencer with a behavioural MAC
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [5:0]  cfg_out_sel = '0;
    logic        cfg_rnd = 1'b0, cfg_sat = 1'b0, cfg_tc = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_oper = '0, in_coef = '0;
    logic        clk_en;
    logic [15:0] oper_d, coef_d;
    logic        acc_clear, acc_rnd, acc_sat, mac_tc;
    logic [5:0]  out_sel;
    logic [15:0] mac_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_dot_sequencer #(.LEN_W(8)) dut (
        .MAC_ACC_CLK(clk), .acc_ff_rstn(rstn),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_out_sel(cfg_out_sel),
        .cfg_rnd(cfg_rnd), .cfg_sat(cfg_sat), .cfg_tc(cfg_tc),
        .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper), .in_coef(in_coef),
        .EFPGA_MATHB_CLK_EN(clk_en), .MAC_OPER_DATA(oper_d), .MAC_COEF_DATA(coef_d),
        .MAC_ACC_CLEAR(acc_clear), .MAC_ACC_RND(acc_rnd), .MAC_ACC_SAT(acc_sat),
        .MAC_TC(mac_tc), .MAC_OUT_SEL(out_sel), .MAC_OUT(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    // Behavioural 40-bit MAC accumulator slice
    logic signed [39:0] acc, prod, base, shifted;
    always_comb begin
        if (mac_tc) prod = $signed({{24{oper_d[15]}}, oper_d}) * $signed({{24{coef_d[15]}}, coef_d});
        else        prod = $signed({24'b0, oper_d} * {24'b0, coef_d});
        if (acc_clear)    base = '0;
        else if (acc_rnd) base = (out_sel == 6'd0) ? 40'sd0 : (40'sd1 <<< (out_sel - 6'd1));
        else              base = acc;
        shifted = acc >>> out_sel;
        if (acc_sat && shifted > 40'sd32767)       mac_out = 16'h7FFF;
        else if (acc_sat && shifted < -40'sd32768) mac_out = 16'h8000;
        else                                       mac_out = shifted[15:0];
    end
    always @(posedge clk or negedge rstn) begin
        if (!rstn)       acc <= '0;
        else if (clk_en) acc <= base + prod;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] len, input logic [5:0] sel,
                             input logic rnd, input logic sat, input logic tc);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_len = len; cfg_out_sel = sel;
        cfg_rnd = rnd; cfg_sat = sat; cfg_tc = tc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // returns the CLK_EN/CLEAR/RND seen in the cycle after the beat is accepted
    task automatic send_beat(input logic [15:0] op, input logic [15:0] cf,
                             output logic en, output logic clr, output logic rnd);
        logic rdy;
        int   n;
        in_valid = 1'b1; in_oper = op; in_coef = cf;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!rdy) check("beat_timeout", 16'd0, 16'd1);
        in_valid = 1'b0;
        en = clk_en; clr = acc_clear; rnd = acc_rnd;
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp, output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!res_valid && n < 30);
        lat = n;
        check(tag, res_data, exp);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_done"}, {14'd0, res_valid, busy}, 16'd0);
    endtask

    logic en, clr, rnd;
    int   lat;
    logic [15:0] oper_t [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [15:0] coef_t [4] = '{16'd5, 16'd6, 16'd7, 16'd8};

    initial begin
        #12;
        check("reset_outs", {res_data}, 16'd0);
        check("reset_flags", {9'd0, busy, in_ready, clk_en, acc_clear, acc_rnd, res_valid, acc_sat, mac_tc}, 16'd0);
        @(posedge clk); #1 rstn = 1'b1;

        // len=0 start is ignored
        start_job(8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        check("len0_ignored", {14'd0, busy, in_ready}, 16'd0);

        // test 1: unsigned dot product 1*5+2*6+3*7+4*8 = 70
        start_job(8'd4, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t1_busy_ready", {14'd0, busy, in_ready}, 16'd3);
        for (int i = 0; i < 4; i++) begin
            send_beat(oper_t[i], coef_t[i], en, clr, rnd);
            check($sformatf("t1_beat%0d_en_clr_rnd", i), {13'd0, en, clr, rnd},
                  (i == 0) ? 16'd6 : 16'd4);
        end
        check("t1_drain_ready", {15'd0, in_ready}, 16'd0);
        get_result("t1_result", 16'h0046, lat);
        check("t1_latency", 16'(lat), 16'd3);

        // test 2: signed -1*3 twice = -6
        start_job(8'd2, 6'd0, 1'b0, 1'b0, 1'b1);
        check("t2_tc", {15'd0, mac_tc}, 16'd1);
        send_beat(16'hFFFF, 16'h0003, en, clr, rnd);
        send_beat(16'hFFFF, 16'h0003, en, clr, rnd);
        get_result("t2_result", 16'hFFFA, lat);

        // test 3: 0xFFFF*0xFFFF unsigned, saturated and wrapped
        start_job(8'd1, 6'd0, 1'b0, 1'b1, 1'b0);
        send_beat(16'hFFFF, 16'hFFFF, en, clr, rnd);
        get_result("t3_sat", 16'h7FFF, lat);
        start_job(8'd1, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(16'hFFFF, 16'hFFFF, en, clr, rnd);
        get_result("t3_nosat", 16'h0001, lat);

        // test 4: 3*8=24 at out_sel=4, with and without rounding
        start_job(8'd1, 6'd4, 1'b1, 1'b0, 1'b0);
        check("t4_out_sel", {10'd0, out_sel}, 16'd4);
        send_beat(16'd3, 16'd8, en, clr, rnd);
        check("t4_rnd_first", {13'd0, en, clr, rnd}, 16'd5);
        get_result("t4_rnd", 16'h0002, lat);
        check("t4_sel_idle", {10'd0, out_sel}, 16'd0);
        start_job(8'd1, 6'd4, 1'b0, 1'b0, 1'b0);
        send_beat(16'd3, 16'd8, en, clr, rnd);
        get_result("t4_trunc", 16'h0001, lat);

        // test 5: stalled source, held result, start during HOLD ignored
        start_job(8'd3, 6'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            send_beat(16'(i), 16'd1, en, clr, rnd);
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        check("t5_valid", {15'd0, res_valid}, 16'd1);
        check("t5_data", res_data, 16'd6);
        cfg_start = 1'b1; cfg_len = 8'd5;
        repeat (5) @(posedge clk);
        #1 cfg_start = 1'b0;
        check("t5_hold_stable", {13'd0, res_valid, busy, in_ready}, 16'd6);
        check("t5_data_stable", res_data, 16'd6);
        get_result("t5_result", 16'd6, lat);
        start_job(8'd2, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(16'd2, 16'd5, en, clr, rnd);
        send_beat(16'd2, 16'd5, en, clr, rnd);
        get_result("t5_next_job", 16'h0014, lat);

        // test 6: asynchronous reset mid-RUN
        start_job(8'd3, 6'd7, 1'b0, 1'b1, 1'b1);
        send_beat(16'd9, 16'd9, en, clr, rnd);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_flags", {9'd0, busy, in_ready, clk_en, acc_clear, acc_rnd, res_valid, acc_sat, mac_tc}, 16'd0);
        check("t6_rst_oper", oper_d, 16'd0);
        check("t6_rst_sel", {10'd0, out_sel}, 16'd0);
        @(posedge clk); #1 rstn = 1'b1;
        start_job(8'd1, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(16'd2, 16'd3, en, clr, rnd);
        get_result("t6_after_reset", 16'h0006, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Control sequencer that drives one 16-bit MAC accumulator slice of the eFPGA math block. Accepts a configured dot-product job (length, output shift, round/saturate/signed mode), streams operand/coefficient pairs from a valid/ready source into the MAC operand and control inputs, and captures the MAC's 16-bit output into a result register with a valid/ready handshake. It is the initiator side of the MAC control interface.

## Interface
- LEN_W, 8, width of the job length; max job = 2^LEN_W-1 products.
- MAC_ACC_CLK  in  1  clock, shared with the MAC accumulator.
- acc_ff_rstn  in  1  asynchronous active-low reset, shared with the MAC.
- cfg_start  in  1  one-cycle job start request.
- cfg_len  in  LEN_W  number of products; 0 = start ignored.
- cfg_out_sel  in  6  result bit offset (0..24); larger values passed through unchanged.
- cfg_rnd / cfg_sat / cfg_tc  in  1 each  round, saturate, two's-complement mode.
- in_valid / in_ready  in / out  1  operand stream handshake.
- in_oper / in_coef  in  16 each  operand and coefficient.
- EFPGA_MATHB_CLK_EN  out  1  MAC accumulate enable.
- MAC_OPER_DATA / MAC_COEF_DATA  out  16 each  MAC operands.
- MAC_ACC_CLEAR / MAC_ACC_RND  out  1 each  first-product feedback select.
- MAC_ACC_SAT / MAC_TC  out  1 each  mode to MAC.
- MAC_OUT_SEL  out  6  output bit offset to MAC.
- MAC_OUT  in  16  MAC result (combinational from MAC accumulator register).
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  16  captured result.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RUN, DRAIN, CAPT, HOLD. All outputs registered; reset value 0 for every output, state=IDLE.
- IDLE: in_ready=0. cfg_start with cfg_len!=0 latches len/out_sel/rnd/sat/tc, loads count=cfg_len, goes RUN. cfg_start with cfg_len==0 ignored.
- Latched config drives MAC_OUT_SEL, MAC_ACC_SAT, MAC_TC from the cycle after start until return to IDLE; held stable through capture. Returns to 0 in IDLE.
- RUN: in_ready=1. Each accepted beat (in_valid&in_ready) registers in_oper/in_coef onto MAC_OPER_DATA/MAC_COEF_DATA and sets EFPGA_MATHB_CLK_EN=1 for the next cycle; count decrements. Cycle without a beat: CLK_EN=0, operands hold.
- First beat of a job: MAC_ACC_CLEAR=1 (cfg_rnd=0) or MAC_ACC_RND=1 (cfg_rnd=1) in the same cycle its CLK_EN=1; never both; 0 on all other cycles. Prior job's accumulator content never leaks.
- Last beat accepted (count 1->0): in_ready drops next cycle, go DRAIN.
- DRAIN: last product applied (CLK_EN=1 this cycle); go CAPT.
- CAPT: CLK_EN=0; MAC_OUT valid; res_data<=MAC_OUT, res_valid<=1, go HOLD.
- HOLD: res_data/res_valid stable until res_ready; on handshake res_valid<=0, go IDLE.
- cfg_start ignored while busy. No abort other than reset.
- Arithmetic entirely in the MAC (40-bit accumulator); 255 full-scale 32-bit products cannot overflow it.

## Timing
- Start edge s: RUN from cycle s+1; first beat acceptable at edge s+1.
- Last beat accepted at edge e: CLK_EN=1 in cycle e+1, accumulator updates at edge e+1, res_data captured at edge e+2, res_valid high from cycle after edge e+2.
- Back-to-back beats: N products complete in N+3 edges after start accepted plus stall cycles.
- res_ready high in same cycle res_valid rises: result consumed at that edge; next cfg_start accepted in the following IDLE cycle.
- Reset mid-job: all outputs 0 immediately (asynchronous), state IDLE; the MAC accumulator resets on the same signal.

## Test plan
- len=4, tc=0, out_sel=0, oper {1,2,3,4}, coef {5,6,7,8} back-to-back -> res_data=0x0046, res_valid rises 3 edges after 4th beat, CLEAR high only with first CLK_EN.
- tc=1, len=2, oper 0xFFFF, coef 0x0003 both beats -> res_data=0xFFFA.
- tc=0, len=1, 0xFFFF*0xFFFF, out_sel=0: sat=1 -> 0x7FFF; sat=0 -> 0x0001.
- len=1, oper 3, coef 8, out_sel=4: rnd=1 -> 0x0002 with RND (not CLEAR) on first beat; rnd=0 -> 0x0001.
- in_valid toggling every other cycle, res_ready low 5 cycles, cfg_start pulsed during HOLD -> correct result held stable, start ignored, next job's result excludes previous sum.
- acc_ff_rstn asserted mid-RUN -> all outputs 0 at once, busy=0; following len=1 job 2*3 -> 0x0006.
